// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, immediate/ALU/PC/WB selects, states.
// Pure declarations, no timing or handshake behaviour.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_U = 3'd1;
    localparam logic [2:0] EXT_S = 3'd2;
    localparam logic [2:0] EXT_B = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    // ALU_COPYB sits outside the {funct7[5],funct3} space used by real RV32I ops
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_COPYB = 4'b1111;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_REG   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH,
        CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_ILL
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instr -> immediate format, ALU operand/op selects, class, legality.
// Zero latency, no handshake.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  ext_op,
    output logic        alu_asrc,
    output logic        alu_bsrc,
    output logic [3:0]  alu_ctr,
    output iclass_t     cls,
    output logic        legal
);

    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    assign f7b5        = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        cls      = CL_ILL;
        ext_op   = EXT_I;
        alu_asrc = 1'b0;
        alu_bsrc = 1'b1;
        alu_ctr  = ALU_ADD;
        case (instr[6:0])
            OPC_LUI: begin
                cls     = CL_LUI;
                ext_op  = EXT_U;
                alu_ctr = ALU_COPYB;
            end
            OPC_AUIPC: begin
                cls      = CL_AUIPC;
                ext_op   = EXT_U;
                alu_asrc = 1'b1;
            end
            OPC_JAL: begin
                cls      = CL_JAL;
                ext_op   = EXT_J;
                alu_asrc = 1'b1;
            end
            OPC_JALR:  cls = CL_JALR;
            OPC_BRANCH: begin
                cls      = CL_BRANCH;
                ext_op   = EXT_B;
                alu_bsrc = 1'b0;
            end
            OPC_LOAD:  cls = CL_LOAD;
            OPC_STORE: begin
                cls    = CL_STORE;
                ext_op = EXT_S;
            end
            OPC_OPIMM: begin
                cls = CL_OPIMM;
                // only shifts carry funct7[5] (SRAI vs SRLI); elsewhere bit 30 is immediate data
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    alu_ctr = {f7b5, funct3};
                else
                    alu_ctr = {1'b0, funct3};
            end
            OPC_OP: begin
                cls      = CL_OP;
                alu_bsrc = 1'b0;
                alu_ctr  = {f7b5, funct3};
            end
            default: ;
        endcase
    end

    assign legal = (cls != CL_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction at zero wait.
// imem/dmem requests held until ready or timeout (-> sticky bus_err, TRAP until reset).
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  ext_op,
    output logic        alu_asrc,
    output logic        alu_bsrc,
    output logic [3:0]  alu_ctr,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err
);

    localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

    state_t     state;
    iclass_t    cls;
    logic       legal;
    logic [7:0] wait_cnt;
    logic       tmo_hit;

    ctrl_decode u_decode (
        .instr    (instr),
        .ext_op   (ext_op),
        .alu_asrc (alu_asrc),
        .alu_bsrc (alu_bsrc),
        .alu_ctr  (alu_ctr),
        .cls      (cls),
        .legal    (legal)
    );

    // fires on the wait cycle that would bring the count up to the limit
    assign tmo_hit = (TMO != 8'd0) && ((wait_cnt + 8'd1) == TMO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (tmo_hit) begin
                        imem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= ST_TRAP;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        state <= ST_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= '0;
                    if (cls == CL_BRANCH) begin
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end else if (cls == CL_LOAD || cls == CL_STORE) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == CL_STORE);
                        state    <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (cls == CL_STORE) begin
                            wait_cnt <= '0;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_WB;
                        end
                    end else if (tmo_hit) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= ST_TRAP;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WB: begin
                    wait_cnt <= '0;
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_TRAP: ;
                default: state <= ST_TRAP;
            endcase
        end
    end

    // pulses are gated by rst_n so an instruction aborted by reset never commits
    assign ir_we  = rst_n && (state == ST_FETCH) && imem_req && imem_ready;
    assign reg_we = rst_n && (state == ST_WB);
    assign pc_we  = rst_n && (((state == ST_EXEC) && (cls == CL_BRANCH))
                           || ((state == ST_MEM) && (cls == CL_STORE) && dmem_req && dmem_ready)
                           || (state == ST_WB));

    always_comb begin
        pc_sel = PC_SEL_PLUS4;
        if (state == ST_EXEC && cls == CL_BRANCH && branch_taken)
            pc_sel = PC_SEL_IMM;
        else if (state == ST_WB && cls == CL_JAL)
            pc_sel = PC_SEL_IMM;
        else if (state == ST_WB && cls == CL_JALR)
            pc_sel = PC_SEL_REG;
    end

    always_comb begin
        wb_sel = WB_ALU;
        if (cls == CL_LOAD)
            wb_sel = WB_MEM;
        else if (cls == CL_JAL || cls == CL_JALR)
            wb_sel = WB_PC4;
    end

endmodule
